// File: rtl/stack_controller.sv
// Multicycle control FSM for the 8-bit stack-machine CPU: decodes `inst` into datapath strobes.
// Optional retired-instruction counter enabled by defining STACK_CTRL_PERF_EN.
module stack_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] inst,
  output logic       ld_IR,
  output logic       PCorIR,
  output logic       push,
  output logic       pop,
  output logic       MEMorALU,
  output logic       ldA,
  output logic       ldB,
  output logic       PCup,
  output logic       PCwrite,
  output logic       J,
  output logic       JZ,
  output logic       write_enable,
  output logic [1:0] ALUop,
  output logic [7:0] retired
);

  localparam int unsigned RET_W = 8;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_PUSH = 3'b100;
  localparam logic [2:0] OP_POP  = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_JZ   = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_POPA    = 4'd2,
    S_POPB    = 4'd3,
    S_ALU     = 4'd4,
    S_PUSHALU = 4'd5,
    S_MEMRD   = 4'd6,
    S_PUSHMEM = 4'd7,
    S_MEMWR   = 4'd8,
    S_BRZ     = 4'd9
  } state_t;

  state_t state_q, state_d;

  // State register; reset lands in FETCH
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state and strobe decode; reset forces every strobe low
  always_comb begin
    state_d      = S_FETCH;
    ld_IR        = 1'b0;
    PCorIR       = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    MEMorALU     = 1'b0;
    ldA          = 1'b0;
    ldB          = 1'b0;
    PCup         = 1'b1;
    PCwrite      = 1'b0;
    J            = 1'b0;
    JZ           = 1'b0;
    write_enable = 1'b0;
    ALUop        = 2'b00;

    case (state_q)
      S_FETCH: begin
        ld_IR   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (inst)
          OP_PUSH: begin
            PCwrite = 1'b1;
            state_d = S_MEMRD;
          end
          OP_JMP: begin
            PCwrite = 1'b1;
            J       = 1'b1;
            state_d = S_FETCH;
          end
          OP_JZ:   state_d = S_POPA;
          default: begin
            PCwrite = 1'b1;
            state_d = S_POPA;
          end
        endcase
      end
      S_POPA: begin
        pop = 1'b1;
        ldA = 1'b1;
        case (inst)
          OP_ADD, OP_SUB, OP_AND: state_d = S_POPB;
          OP_NOT:                 state_d = S_ALU;
          OP_POP:                 state_d = S_MEMWR;
          OP_JZ:                  state_d = S_BRZ;
          default:                state_d = S_FETCH;
        endcase
      end
      S_POPB: begin
        pop     = 1'b1;
        ldB     = 1'b1;
        state_d = S_ALU;
      end
      S_ALU: begin
        PCup    = 1'b0;
        ALUop   = inst[1:0];
        state_d = S_PUSHALU;
      end
      S_PUSHALU: begin
        push     = 1'b1;
        MEMorALU = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMRD: begin
        PCorIR  = 1'b1;
        state_d = S_PUSHMEM;
      end
      S_PUSHMEM: begin
        push    = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        PCorIR       = 1'b1;
        write_enable = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRZ: begin
        JZ      = 1'b1;
        PCwrite = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (rst) begin
      ld_IR        = 1'b0;
      PCorIR       = 1'b0;
      push         = 1'b0;
      pop          = 1'b0;
      MEMorALU     = 1'b0;
      ldA          = 1'b0;
      ldB          = 1'b0;
      PCup         = 1'b0;
      PCwrite      = 1'b0;
      J            = 1'b0;
      JZ           = 1'b0;
      write_enable = 1'b0;
      ALUop        = 2'b00;
    end
  end

`ifdef STACK_CTRL_PERF_EN
  logic             last_c;
  logic [RET_W-1:0] retired_q;

  // An instruction retires on the edge leaving its final state
  assign last_c = (state_q == S_PUSHALU) || (state_q == S_PUSHMEM) ||
                  (state_q == S_MEMWR)   || (state_q == S_BRZ)     ||
                  ((state_q == S_DECODE) && (inst == OP_JMP));

  always_ff @(posedge clk) begin
    if (rst)         retired_q <= '0;
    else if (last_c) retired_q <= retired_q + RET_W'(1);
  end

  assign retired = rst ? '0 : retired_q;
`else
  assign retired = '0;
`endif

endmodule

// File: tb/tb_stack_controller.sv
// Self-checking bench for stack_controller: directed vector table, random instruction stream
// against a per-opcode sequence model, mid-instruction reset, and retired-counter wrap.
module tb_stack_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] inst;
  logic       ld_IR, PCorIR, push, pop, MEMorALU, ldA, ldB, PCup, PCwrite, J, JZ, write_enable;
  logic [1:0] ALUop;
  logic [7:0] retired;
  logic [13:0] outs;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_done = 0;

  stack_controller dut (
    .clk(clk), .rst(rst), .inst(inst),
    .ld_IR(ld_IR), .PCorIR(PCorIR), .push(push), .pop(pop), .MEMorALU(MEMorALU),
    .ldA(ldA), .ldB(ldB), .PCup(PCup), .PCwrite(PCwrite), .J(J), .JZ(JZ),
    .write_enable(write_enable), .ALUop(ALUop), .retired(retired)
  );

  always #5 clk = ~clk;

  // {ld_IR, PCorIR, push, pop, MEMorALU, ldA, ldB, PCup, PCwrite, J, JZ, write_enable, ALUop}
  assign outs = {ld_IR, PCorIR, push, pop, MEMorALU, ldA, ldB, PCup, PCwrite, J, JZ,
                 write_enable, ALUop};

  // Named phases of an instruction as seen on the strobe vector
  localparam logic [13:0] P_FETCH   = 14'b1_0_0_0_0_0_0_1_0_0_0_0_00;
  localparam logic [13:0] P_DEC     = 14'b0_0_0_0_0_0_0_1_1_0_0_0_00;
  localparam logic [13:0] P_DEC_J   = 14'b0_0_0_0_0_0_0_1_1_1_0_0_00;
  localparam logic [13:0] P_DEC_JZ  = 14'b0_0_0_0_0_0_0_1_0_0_0_0_00;
  localparam logic [13:0] P_POPA    = 14'b0_0_0_1_0_1_0_1_0_0_0_0_00;
  localparam logic [13:0] P_POPB    = 14'b0_0_0_1_0_0_1_1_0_0_0_0_00;
  localparam logic [13:0] P_PUSHALU = 14'b0_0_1_0_1_0_0_1_0_0_0_0_00;
  localparam logic [13:0] P_MEMRD   = 14'b0_1_0_0_0_0_0_1_0_0_0_0_00;
  localparam logic [13:0] P_PUSHMEM = 14'b0_0_1_0_0_0_0_1_0_0_0_0_00;
  localparam logic [13:0] P_MEMWR   = 14'b0_1_0_0_0_0_0_1_0_0_0_1_00;
  localparam logic [13:0] P_BRZ     = 14'b0_0_0_0_0_0_0_1_1_0_1_0_00;

  typedef logic [13:0] seq_q_t[$];

  // Per-opcode list of expected strobe vectors, one per cycle, starting at fetch
  function automatic seq_q_t model_seq(input logic [2:0] op);
    seq_q_t s;
    logic [13:0] alu_v;
    alu_v = {12'b0, op[1:0]};
    case (op)
      3'b000, 3'b001, 3'b010: s = {P_FETCH, P_DEC, P_POPA, P_POPB, alu_v, P_PUSHALU};
      3'b011:  s = {P_FETCH, P_DEC, P_POPA, alu_v, P_PUSHALU};
      3'b100:  s = {P_FETCH, P_DEC, P_MEMRD, P_PUSHMEM};
      3'b101:  s = {P_FETCH, P_DEC, P_POPA, P_MEMWR};
      3'b110:  s = {P_FETCH, P_DEC_J};
      default: s = {P_FETCH, P_DEC_JZ, P_POPA, P_BRZ};
    endcase
    return s;
  endfunction

  function automatic logic [7:0] exp_retired();
`ifdef STACK_CTRL_PERF_EN
    return 8'(n_done);
`else
    return 8'd0;
`endif
  endfunction

  task automatic chk_out(input string tag, input logic [13:0] exp);
    n_cmp++;
    if (outs !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t outs=%b expected=%b", tag, $time, outs, exp);
    end
  endtask

  task automatic chk_ret(input string tag);
    logic [7:0] e;
    e = exp_retired();
    n_cmp++;
    if (retired !== e) begin
      n_fail++;
      $display("FAIL %s_retired t=%0t retired=%0d expected=%0d", tag, $time, retired, e);
    end
  endtask

  // Entered just after a falling edge; leaves on the next falling edge
  task automatic cyc(input logic [2:0] op, input logic [13:0] exp, input string tag);
    inst = op;
    #1;
    chk_out(tag, exp);
    chk_ret(tag);
    @(negedge clk);
  endtask

  task automatic run_instr(input logic [2:0] op, input string tag);
    seq_q_t s;
    s = model_seq(op);
    foreach (s[k]) cyc(op, s[k], tag);
    n_done++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk_out("reset_outs", 14'b0);
    n_cmp++;
    if (retired !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_retired retired=%0d expected=0", retired);
    end
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [13:0] exp;
    logic        last;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // Directed cycle table: ADD, NOT, PUSH, POP, JMP, JZ, SUB, AND
    tbl.push_back('{3'b000, 14'b1_0_0_0_0_0_0_1_0_0_0_0_00, 1'b0});
    tbl.push_back('{3'b000, 14'b0_0_0_0_0_0_0_1_1_0_0_0_00, 1'b0});
    tbl.push_back('{3'b000, 14'b0_0_0_1_0_1_0_1_0_0_0_0_00, 1'b0});
    tbl.push_back('{3'b000, 14'b0_0_0_1_0_0_1_1_0_0_0_0_00, 1'b0});
    tbl.push_back('{3'b000, 14'b0_0_0_0_0_0_0_0_0_0_0_0_00, 1'b0});
    tbl.push_back('{3'b000, 14'b0_0_1_0_1_0_0_1_0_0_0_0_00, 1'b1});
    tbl.push_back('{3'b011, 14'b1_0_0_0_0_0_0_1_0_0_0_0_00, 1'b0});
    tbl.push_back('{3'b011, 14'b0_0_0_0_0_0_0_1_1_0_0_0_00, 1'b0});
    tbl.push_back('{3'b011, 14'b0_0_0_1_0_1_0_1_0_0_0_0_00, 1'b0});
    tbl.push_back('{3'b011, 14'b0_0_0_0_0_0_0_0_0_0_0_0_11, 1'b0});
    tbl.push_back('{3'b011, 14'b0_0_1_0_1_0_0_1_0_0_0_0_00, 1'b1});
    tbl.push_back('{3'b100, 14'b1_0_0_0_0_0_0_1_0_0_0_0_00, 1'b0});
    tbl.push_back('{3'b100, 14'b0_0_0_0_0_0_0_1_1_0_0_0_00, 1'b0});
    tbl.push_back('{3'b100, 14'b0_1_0_0_0_0_0_1_0_0_0_0_00, 1'b0});
    tbl.push_back('{3'b100, 14'b0_0_1_0_0_0_0_1_0_0_0_0_00, 1'b1});
    tbl.push_back('{3'b101, 14'b1_0_0_0_0_0_0_1_0_0_0_0_00, 1'b0});
    tbl.push_back('{3'b101, 14'b0_0_0_0_0_0_0_1_1_0_0_0_00, 1'b0});
    tbl.push_back('{3'b101, 14'b0_0_0_1_0_1_0_1_0_0_0_0_00, 1'b0});
    tbl.push_back('{3'b101, 14'b0_1_0_0_0_0_0_1_0_0_0_1_00, 1'b1});
    tbl.push_back('{3'b110, 14'b1_0_0_0_0_0_0_1_0_0_0_0_00, 1'b0});
    tbl.push_back('{3'b110, 14'b0_0_0_0_0_0_0_1_1_1_0_0_00, 1'b1});
    tbl.push_back('{3'b111, 14'b1_0_0_0_0_0_0_1_0_0_0_0_00, 1'b0});
    tbl.push_back('{3'b111, 14'b0_0_0_0_0_0_0_1_0_0_0_0_00, 1'b0});
    tbl.push_back('{3'b111, 14'b0_0_0_1_0_1_0_1_0_0_0_0_00, 1'b0});
    tbl.push_back('{3'b111, 14'b0_0_0_0_0_0_0_1_1_0_1_0_00, 1'b1});
    tbl.push_back('{3'b001, 14'b1_0_0_0_0_0_0_1_0_0_0_0_00, 1'b0});
    tbl.push_back('{3'b001, 14'b0_0_0_0_0_0_0_1_1_0_0_0_00, 1'b0});
    tbl.push_back('{3'b001, 14'b0_0_0_1_0_1_0_1_0_0_0_0_00, 1'b0});
    tbl.push_back('{3'b001, 14'b0_0_0_1_0_0_1_1_0_0_0_0_00, 1'b0});
    tbl.push_back('{3'b001, 14'b0_0_0_0_0_0_0_0_0_0_0_0_01, 1'b0});
    tbl.push_back('{3'b001, 14'b0_0_1_0_1_0_0_1_0_0_0_0_00, 1'b1});
    tbl.push_back('{3'b010, 14'b1_0_0_0_0_0_0_1_0_0_0_0_00, 1'b0});
    tbl.push_back('{3'b010, 14'b0_0_0_0_0_0_0_1_1_0_0_0_00, 1'b0});
    tbl.push_back('{3'b010, 14'b0_0_0_1_0_1_0_1_0_0_0_0_00, 1'b0});
    tbl.push_back('{3'b010, 14'b0_0_0_1_0_0_1_1_0_0_0_0_00, 1'b0});
    tbl.push_back('{3'b010, 14'b0_0_0_0_0_0_0_0_0_0_0_0_10, 1'b0});
    tbl.push_back('{3'b010, 14'b0_0_1_0_1_0_0_1_0_0_0_0_00, 1'b1});

    rst  = 1'b1;
    inst = 3'b000;
    @(negedge clk);
    do_reset();

    foreach (tbl[i]) begin
      cyc(tbl[i].op, tbl[i].exp, "table");
      if (tbl[i].last) n_done++;
    end

    // Random instruction stream against the sequence model
    for (int n = 0; n < 400; n++) run_instr(3'($urandom_range(0, 7)), "random");

    // Reset held two cycles while an ADD sits in POPB
    cyc(3'b000, P_FETCH, "midrst_fetch");
    cyc(3'b000, P_DEC,   "midrst_dec");
    cyc(3'b000, P_POPA,  "midrst_popa");
    inst = 3'b000;
    #1;
    chk_out("midrst_popb", P_POPB);
    rst = 1'b1;
    #1;
    chk_out("midrst_hold0", 14'b0);
    @(negedge clk);
    #1;
    chk_out("midrst_hold1", 14'b0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    cyc(3'b000, P_FETCH, "midrst_after");
    cyc(3'b000, P_DEC,   "midrst_after_dec");
    // Abandon the partial ADD cleanly before the wrap test
    do_reset();

    // 256 back-to-back JMPs wrap the retired counter back to zero
    for (int n = 0; n < 256; n++) run_instr(3'b110, "jmp_wrap");
    cyc(3'b000, P_FETCH, "wrap_fetch");
    n_cmp++;
    if (retired !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_zero retired=%0d expected=0", retired);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_controller.md
# stack_controller

Multicycle control FSM for the 8-bit stack-machine CPU; sits directly upstream of the datapath, consuming its decoded opcode `inst` and producing every datapath load, select, stack and memory strobe. State advances on `posedge clk`. Datapath registers sample on `negedge clk`, so each state's outputs are settled half a cycle before they are used. One instruction runs in 2–6 states. There is no pipelining: the next fetch starts only after the current instruction's last state.

## Interface
- No parameters.
- `clk` in 1: system clock; state register updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `inst` in 3: opcode from the datapath.
  - 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH, 101 POP, 110 JMP, 111 JZ.
- `ld_IR` out 1: load IR from memory.
- `PCorIR` out 1: memory address select; 1 = IR[4:0], 0 = PC.
- `push` out 1: push onto stack.
- `pop` out 1: pop from stack.
- `MEMorALU` out 1: stack input select; 1 = ALUres, 0 = MDR.
- `ldA` out 1: load A from stack top.
- `ldB` out 1: load B from stack top.
- `PCup` out 1: ALU operands become PC and 1.
- `PCwrite` out 1: load PC.
- `J` out 1: PC source becomes IR[4:0], unconditionally.
- `JZ` out 1: PC source becomes IR[4:0] when A==0.
- `write_enable` out 1: memory write of A.
- `ALUop` out 2: ALU function.
  - 00 add, 01 sub, 10 and, 11 not.
- `retired` out 8: count of completed instructions (see Configuration).

## Operation
- Default outputs in every state: all strobes 0, `PCup`=1, `ALUop`=00.
  - Effect: ALUres tracks PC+1 except in ALU.
- FETCH: `ld_IR`=1, `PCorIR`=0. Next state: DECODE.
- DECODE (`inst` valid):
  - ADD/SUB/AND/NOT/POP: `PCwrite`=1. Next state: POPA.
  - PUSH: `PCwrite`=1. Next state: MEMRD.
  - JMP: `PCwrite`=1, `J`=1. Next state: FETCH.
  - JZ: no `PCwrite`, so PC is held. Next state: POPA.
- POPA: `pop`=1, `ldA`=1. Next state depends on `inst`:
  - ADD/SUB/AND: POPB.
  - NOT: ALU.
  - POP: MEMWR.
  - JZ: BRZ.
- POPB: `pop`=1, `ldB`=1. Next state: ALU.
- ALU: `PCup`=0, `ALUop` = `inst[1:0]`. Next state: PUSHALU.
- PUSHALU: `push`=1, `MEMorALU`=1. Next state: FETCH.
- MEMRD: `PCorIR`=1; MDR captures mem[IR[4:0]]. Next state: PUSHMEM.
- PUSHMEM: `push`=1, `MEMorALU`=0. Next state: FETCH.
- MEMWR: `PCorIR`=1, `write_enable`=1. Next state: FETCH.
- BRZ: `JZ`=1, `PCwrite`=1.
  - PC becomes IR[4:0] if A==0, else ALUres (PC+1).
  - Next state: FETCH.
- Unused state encodings go to FETCH with all strobes 0.

## Timing
- Cycles per instruction:
  - ADD/SUB/AND: 6.
  - NOT: 5.
  - PUSH, POP, JZ: 4.
  - JMP: 2.
- Outputs are a function of the state register plus `inst`. `inst` is used only in DECODE, POPA and ALU.
- `inst` must stay stable from DECODE until the instruction's last state. This holds because IR is loaded only in FETCH.
- Reset:
  - While `rst`=1, every output is forced to 0, including `PCup` and `ALUop`.
  - The state register loads FETCH on the first rising edge with `rst`=1.
  - `rst` asserted mid-instruction aborts the instruction at that edge. Partially completed pops and pushes are not undone.
- `push` and `pop` are never asserted in the same state.
- `write_enable` is never asserted together with `ld_IR`.

## Configuration
- Macro: `STACK_CTRL_PERF_EN`.
- Defined:
  - `retired` is an 8-bit counter, reset to 0.
  - It increments by 1 on the rising edge that leaves the last state of each instruction: PUSHALU, PUSHMEM, MEMWR, BRZ, or DECODE for JMP.
  - It wraps 255→0.
- Not defined: `retired` is tied to 8'd0 and no counter logic exists.

## Test plan
- Reset: hold `rst` 2 cycles mid-ADD (in POPB) → all outputs 0 during reset; first state after release is FETCH (`ld_IR`=1, `PCup`=1); `retired`=0.
- ADD (`inst`=000): state sequence FETCH, DECODE, POPA, POPB, ALU, PUSHALU over 6 cycles.
  - ALU state: `ALUop`=00, `PCup`=0.
  - PUSHALU: `push`=1, `MEMorALU`=1.
- NOT (`inst`=011): 5 cycles, POPB skipped; `ALUop`=11 in ALU.
- PUSH then POP: PUSH gives MEMRD with `PCorIR`=1, then PUSHMEM with `push`=1, `MEMorALU`=0. POP gives POPA, then MEMWR with `write_enable`=1, `PCorIR`=1.
- JMP (`inst`=110): DECODE drives `J`=1, `PCwrite`=1; FETCH follows on the next cycle.
- JZ (`inst`=111): DECODE has `PCwrite`=0; BRZ has `JZ`=1, `PCwrite`=1, `PCup`=1, `ALUop`=00.
  - With `STACK_CTRL_PERF_EN` defined, 256 back-to-back JMPs wrap `retired` to 0.
